// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// Package : apu_pkg
// Shared constants and sample-format helpers for the APU audio output path.
// Rev     : 1.0
// ============================================================================
package apu_pkg;

    localparam int I2S_SLOTS   = 32;
    localparam int AUDIO_OUT_W = 16;

    // Offset-binary (midscale = silence) to two's complement: flip the MSB.
    function automatic logic [AUDIO_OUT_W-1:0] offset_to_signed(
        input logic [AUDIO_OUT_W-1:0] v
    );
        return {~v[AUDIO_OUT_W-1], v[AUDIO_OUT_W-2:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_i2s_ser.sv
`default_nettype none
// ============================================================================
// Module : apu_i2s_ser
// Registered I2S bclk/lrclk/sdata generation from the frame bit phase.
// Rev    : 1.0
// ============================================================================
module apu_i2s_ser
    import apu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           bit_phase,
    input  logic [I2S_SLOTS-1:0] frame,
    input  logic                 prior_lsb,
    output logic                 i2s_bclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_sdata
);

    logic [4:0] w_slot;
    logic [4:0] w_bit_sel;
    logic       w_bit;

    assign w_slot    = bit_phase[5:1];
    // Slot k carries frame bit 32-k; the modulo-32 wrap of slot 0 is overridden
    // by the one-bclk I2S delay, which sends the previous frame's right LSB.
    assign w_bit_sel = 5'd0 - w_slot;
    assign w_bit     = (w_slot == 5'd0) ? prior_lsb : frame[w_bit_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
        end else begin
            i2s_bclk  <= bit_phase[0];
            i2s_lrclk <= w_slot[4];
            i2s_sdata <= w_bit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apu_audio_i2s.sv
`default_nettype none
// ============================================================================
// Module : apu_audio_i2s
// Box-filter decimator of the APU mix feeding a mono (L=R) I2S transmitter.
// Rev    : 1.0
// ============================================================================
module apu_audio_i2s
    import apu_pkg::*;
#(
    parameter int AUDIO_DEPTH = 16,
    parameter int BCLK_DIV    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AUDIO_DEPTH-1:0] audio,
    input  logic                   audio_en,
    output logic                   i2s_bclk,
    output logic                   i2s_lrclk,
    output logic                   i2s_sdata,
    output logic [AUDIO_OUT_W-1:0] sample_o,
    output logic                   sample_valid
);

    localparam int c_LB    = $clog2(BCLK_DIV);
    localparam int c_LW    = c_LB + 6;
    localparam int c_ACC_W = AUDIO_OUT_W + c_LW;

    logic [c_LW-1:0]        r_phase;
    logic [c_LW-1:0]        w_phase_nxt;
    logic                   w_last;
    logic [AUDIO_OUT_W-1:0] w_audio_lj;
    logic [AUDIO_OUT_W-1:0] w_x;
    logic [c_ACC_W-1:0]     r_acc;
    logic [c_ACC_W-1:0]     w_sum;
    logic [AUDIO_OUT_W-1:0] w_sample_nxt;
    logic [AUDIO_OUT_W-1:0] r_sample;
    logic                   r_sample_valid;
    logic [I2S_SLOTS-1:0]   r_frame;
    logic                   r_prior_lsb;

    generate
        if (AUDIO_DEPTH == AUDIO_OUT_W) begin : g_full_width
            assign w_audio_lj = audio;
        end else begin : g_left_justify
            assign w_audio_lj = {audio, {(AUDIO_OUT_W-AUDIO_DEPTH){1'b0}}};
        end
    endgenerate

    assign w_x          = audio_en ? w_audio_lj : 16'h8000;
    assign w_phase_nxt  = r_phase + c_LW'(1);
    assign w_last       = &r_phase;
    assign w_sum        = r_acc + c_ACC_W'(w_x);
    // Window length is 2**LW, so the floor average is just the upper bits.
    assign w_sample_nxt = offset_to_signed(w_sum[c_ACC_W-1:c_LW]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase        <= '0;
            r_acc          <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_frame        <= '0;
            r_prior_lsb    <= 1'b0;
        end else begin
            r_phase        <= w_phase_nxt;
            r_sample_valid <= w_last;
            if (w_last) begin
                r_acc    <= '0;
                r_sample <= w_sample_nxt;
                r_frame  <= {w_sample_nxt, w_sample_nxt};
            end else begin
                r_acc    <= w_sum;
            end
            // Latch the right LSB one clk before the wrap so slot 0 of the next
            // frame still sees it after the frame word is replaced.
            if (&w_phase_nxt) begin
                r_prior_lsb <= r_frame[0];
            end
        end
    end

    assign sample_o     = r_sample;
    assign sample_valid = r_sample_valid;

    apu_i2s_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .bit_phase (w_phase_nxt[c_LW-1:c_LB]),
        .frame     (r_frame),
        .prior_lsb (r_prior_lsb),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_apu_audio_i2s.sv
`default_nettype none
// ============================================================================
// Module : tb_apu_audio_i2s
// Scoreboard bench: three configurations (BCLK_DIV 1/4, AUDIO_DEPTH 8) in lockstep.
// Rev    : 1.0
// ============================================================================
module tb_apu_audio_i2s;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] audio;
    logic        audio_en;
    logic [7:0]  audio8;
    wire  [2:0]  bclk, lrclk, sdata, svalid;
    wire  [15:0] samp0, samp1, samp2;

    int          pass_cnt  = 0;
    int          check_cnt = 0;
    int          n;
    longint      acc_m   [3];
    logic [31:0] frame_m [3];
    logic        prior_m [3];
    logic [15:0] last_m  [3];
    logic        ev [3], eb [3], el [3], ed [3];
    logic [15:0] q0 [$], q1 [$], q2 [$];

    assign audio8 = audio[15:8];
    always #5 clk = ~clk;

    apu_audio_i2s #(.AUDIO_DEPTH(16), .BCLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .audio(audio), .audio_en(audio_en),
        .i2s_bclk(bclk[0]), .i2s_lrclk(lrclk[0]), .i2s_sdata(sdata[0]),
        .sample_o(samp0), .sample_valid(svalid[0]));

    apu_audio_i2s #(.AUDIO_DEPTH(16), .BCLK_DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .audio(audio), .audio_en(audio_en),
        .i2s_bclk(bclk[1]), .i2s_lrclk(lrclk[1]), .i2s_sdata(sdata[1]),
        .sample_o(samp1), .sample_valid(svalid[1]));

    apu_audio_i2s #(.AUDIO_DEPTH(8), .BCLK_DIV(1)) u_d8 (
        .clk(clk), .rst(rst), .audio(audio8), .audio_en(audio_en),
        .i2s_bclk(bclk[2]), .i2s_lrclk(lrclk[2]), .i2s_sdata(sdata[2]),
        .sample_o(samp2), .sample_valid(svalid[2]));

    function automatic int win_of(input int d);
        return (d == 1) ? 256 : 64;
    endfunction

    function automatic int lb_of(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic logic [15:0] samp_of(input int d);
        case (d)
            0:       return samp0;
            1:       return samp1;
            default: return samp2;
        endcase
    endfunction

    task automatic pop_exp(input int d, output logic [15:0] v);
        v = 16'hxxxx;
        case (d)
            0: if (q0.size() > 0) v = q0.pop_front();
            1: if (q1.size() > 0) v = q1.pop_front();
            default: if (q2.size() > 0) v = q2.pop_front();
        endcase
    endtask

    task automatic reset_model();
        n = 0;
        for (int d = 0; d < 3; d++) begin
            acc_m[d] = 0; frame_m[d] = '0; prior_m[d] = 1'b0; last_m[d] = '0;
            ev[d] = 1'b0; eb[d] = 1'b0; el[d] = 1'b0; ed[d] = 1'b0;
        end
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Apply one clk of input and account for it in the reference averages.
    task automatic drive(input logic [15:0] a, input logic e);
        logic [15:0] x;
        logic [15:0] s;
        int          p;
        audio = a; audio_en = e;
        for (int d = 0; d < 3; d++) begin
            if (!e)          x = 16'h8000;
            else if (d == 2) x = {a[15:8], 8'h00};
            else             x = a;
            p = n % win_of(d);
            acc_m[d] += longint'(x);
            if (p == win_of(d) - 1) begin
                s = 16'(acc_m[d] / longint'(win_of(d)));
                last_m[d] = 16'(s - 16'h8000);
                case (d)
                    0: q0.push_back(last_m[d]);
                    1: q1.push_back(last_m[d]);
                    default: q2.push_back(last_m[d]);
                endcase
                acc_m[d] = 0;
            end
        end
        n++;
    endtask

    // Wait for the sampling edge and derive the expected I2S line state.
    task automatic sync_model();
        int p;
        int slot;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            p = n % win_of(d);
            if (p == 0 && n > 0) begin
                prior_m[d] = frame_m[d][0];
                frame_m[d] = {last_m[d], last_m[d]};
                ev[d] = 1'b1;
            end else begin
                ev[d] = 1'b0;
            end
            slot  = p / (2 * (1 << lb_of(d)));
            eb[d] = ((p / (1 << lb_of(d))) % 2) == 1;
            el[d] = slot >= 16;
            ed[d] = (slot == 0) ? prior_m[d] : frame_m[d][32 - slot];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; audio = 16'h1234; audio_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_cnt++;
            if ({bclk[d], lrclk[d], sdata[d], svalid[d]} !== 4'b0000)
                $display("FAIL reset_lines d%0d: got %b want 0000", d,
                         {bclk[d], lrclk[d], sdata[d], svalid[d]});
            else pass_cnt++;
            check_cnt++;
            if (samp_of(d) !== 16'h0000)
                $display("FAIL reset_sample d%0d: got %h want 0000", d, samp_of(d));
            else pass_cnt++;
        end
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_tone();
        logic [15:0] want;
        for (int c = 0; c < 200; c++) begin
            drive(16'hC000, 1'b1);
            sync_model();
            for (int d = 0; d < 3; d++) begin
                want = 16'hxxxx;
                if (ev[d]) pop_exp(d, want);
                if (ev[d] || svalid[d]) begin
                    check_cnt++;
                    if (svalid[d] !== ev[d])
                        $display("FAIL tone_valid d%0d n=%0d: got %b want %b", d, n, svalid[d], ev[d]);
                    else begin
                        pass_cnt++;
                        check_cnt++;
                        if (samp_of(d) !== want)
                            $display("FAIL tone_sample d%0d n=%0d: got %h want %h", d, n, samp_of(d), want);
                        else pass_cnt++;
                    end
                end
            end
            check_cnt++;
            if ({bclk[0], lrclk[0], sdata[0]} !== {eb[0], el[0], ed[0]})
                $display("FAIL tone_i2s n=%0d: got %b want %b", n,
                         {bclk[0], lrclk[0], sdata[0]}, {eb[0], el[0], ed[0]});
            else pass_cnt++;
        end
    endtask

    task automatic test_disabled();
        logic [15:0] want;
        for (int c = 0; c < 150; c++) begin
            drive(16'($urandom), 1'b0);
            sync_model();
            for (int d = 0; d < 3; d++) begin
                want = 16'hxxxx;
                if (ev[d]) pop_exp(d, want);
                if (ev[d] || svalid[d]) begin
                    check_cnt++;
                    if (svalid[d] !== ev[d])
                        $display("FAIL mute_valid d%0d n=%0d: got %b want %b", d, n, svalid[d], ev[d]);
                    else begin
                        pass_cnt++;
                        check_cnt++;
                        if (samp_of(d) !== want)
                            $display("FAIL mute_sample d%0d n=%0d: got %h want %h", d, n, samp_of(d), want);
                        else pass_cnt++;
                    end
                end
            end
            check_cnt++;
            if (sdata[0] !== ed[0])
                $display("FAIL mute_sdata n=%0d: got %b want %b", n, sdata[0], ed[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_alternating();
        logic [15:0] want;
        for (int c = 0; c < 200; c++) begin
            drive((c % 2 == 0) ? 16'h0000 : 16'hFFFF, 1'b1);
            sync_model();
            for (int d = 0; d < 3; d++) begin
                want = 16'hxxxx;
                if (ev[d]) pop_exp(d, want);
                if (ev[d] || svalid[d]) begin
                    check_cnt++;
                    if (svalid[d] !== ev[d])
                        $display("FAIL alt_valid d%0d n=%0d: got %b want %b", d, n, svalid[d], ev[d]);
                    else begin
                        pass_cnt++;
                        check_cnt++;
                        if (samp_of(d) !== want)
                            $display("FAIL alt_sample d%0d n=%0d: got %h want %h", d, n, samp_of(d), want);
                        else pass_cnt++;
                    end
                end
            end
            check_cnt++;
            if ({lrclk[0], sdata[0]} !== {el[0], ed[0]})
                $display("FAIL alt_i2s n=%0d: got %b want %b", n, {lrclk[0], sdata[0]}, {el[0], ed[0]});
            else pass_cnt++;
        end
    endtask

    task automatic test_bclk_div4();
        logic [15:0] want;
        logic        pb, pl, ps;
        pb = bclk[1]; pl = lrclk[1]; ps = sdata[1];
        for (int c = 0; c < 600; c++) begin
            drive(16'($urandom), ($urandom_range(0, 3) != 0));
            sync_model();
            for (int d = 0; d < 3; d++) begin
                want = 16'hxxxx;
                if (ev[d]) pop_exp(d, want);
                if (ev[d] || svalid[d]) begin
                    check_cnt++;
                    if (svalid[d] !== ev[d])
                        $display("FAIL div4_valid d%0d n=%0d: got %b want %b", d, n, svalid[d], ev[d]);
                    else begin
                        pass_cnt++;
                        check_cnt++;
                        if (samp_of(d) !== want)
                            $display("FAIL div4_sample d%0d n=%0d: got %h want %h", d, n, samp_of(d), want);
                        else pass_cnt++;
                    end
                end
            end
            check_cnt++;
            if ({bclk[1], lrclk[1], sdata[1]} !== {eb[1], el[1], ed[1]})
                $display("FAIL div4_i2s n=%0d: got %b want %b", n,
                         {bclk[1], lrclk[1], sdata[1]}, {eb[1], el[1], ed[1]});
            else pass_cnt++;
            if ((lrclk[1] !== pl) || (sdata[1] !== ps)) begin
                check_cnt++;
                if (!(pb === 1'b1 && bclk[1] === 1'b0))
                    $display("FAIL div4_edge n=%0d: bclk %b->%b want falling edge", n, pb, bclk[1]);
                else pass_cnt++;
            end
            pb = bclk[1]; pl = lrclk[1]; ps = sdata[1];
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] want;
        for (int c = 0; c < 64 && (n % 64) != 37; c++) begin
            drive(16'h2000, 1'b1);
            sync_model();
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check_cnt++;
            if ({bclk[d], lrclk[d], sdata[d], svalid[d]} !== 4'b0000 || samp_of(d) !== 16'h0000)
                $display("FAIL async_rst d%0d: got %b/%h want 0000/0000", d,
                         {bclk[d], lrclk[d], sdata[d], svalid[d]}, samp_of(d));
            else pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int c = 0; c < 140; c++) begin
            drive(16'h9000, 1'b1);
            sync_model();
            for (int d = 0; d < 3; d++) begin
                want = 16'hxxxx;
                if (ev[d]) pop_exp(d, want);
                if (ev[d] || svalid[d]) begin
                    check_cnt++;
                    if (svalid[d] !== ev[d])
                        $display("FAIL post_rst_valid d%0d n=%0d: got %b want %b", d, n, svalid[d], ev[d]);
                    else begin
                        pass_cnt++;
                        check_cnt++;
                        if (samp_of(d) !== want)
                            $display("FAIL post_rst_sample d%0d n=%0d: got %h want %h", d, n, samp_of(d), want);
                        else pass_cnt++;
                    end
                end
            end
            check_cnt++;
            if ({bclk[0], lrclk[0], sdata[0]} !== {eb[0], el[0], ed[0]})
                $display("FAIL post_rst_i2s n=%0d: got %b want %b", n,
                         {bclk[0], lrclk[0], sdata[0]}, {eb[0], el[0], ed[0]});
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_disabled();
        test_alternating();
        test_bclk_div4();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apu_audio_i2s.md
Name: apu_audio_i2s

Overview:
- Downstream of the APU mixer: consumes the per-clock mixed `audio` word and `audio_en` from the apu block.
- Box-filter decimates the stream to one sample per I2S frame, converts offset-binary to two's complement, and serializes it as mono, duplicated L/R, on a standard I2S link to the board DAC.
- Also exposes each decimated sample with a valid strobe, for capture or debug.

Parameters:
- AUDIO_DEPTH, 16: width of the input mix word, 1..16.
- BCLK_DIV, 4: clk cycles per bclk half-period. Must be a power of two ≥1.

Ports:
- clk  in  1  system clock (APU domain).
- rst  in  1  reset. Asynchronous, active-high.
- audio  in  AUDIO_DEPTH  unsigned mixer output; midscale = silence.
- audio_en  in  1  any APU channel enabled.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select: 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first, I2S one-bclk delay.
- sample_o  out  16  latest decimated signed sample.
- sample_valid  out  1  one-clk strobe when sample_o updates.

Behaviour:
- Reset is asynchronous, active-high, on clk/rst. Reset values: all outputs 0, phase counter p=0, accumulator 0, frame word F=0, prior-LSB register 0.
- Derived constants: LB=log2(BCLK_DIV); WIN=64*BCLK_DIV clks per frame; LW=LB+6.
- Phase counter p, LW bits, increments every clk and wraps WIN-1→0.
- All I2S outputs are registered and reflect the current p, so they change on the same edge that p does.
  - i2s_bclk = p[LB].
  - Slot k = p[LW-1:LB+1], range 0..31. Slot k starts on the bclk falling edge at p=k*2*BCLK_DIV.
  - i2s_lrclk = 0 for k=0..15, 1 for k=16..31.
- Serial data per slot:
  - k=0: right-channel LSB of the previous frame (prior-LSB register).
  - k=1..31: F[32-k], so the left MSB is at k=1 and the right MSB at k=17. Each bit is held for a full bclk period.
- Input conditioning: x = audio_en ? {audio, (16-AUDIO_DEPTH) zeros} : 16'h8000. The input is left-justified.
- Accumulator:
  - Width 16+LW, unsigned.
  - On every clk with p≠WIN-1: acc += x.
  - On p==WIN-1: s = (acc + x) >> LW (floor); acc <= 0; sample_o <= {~s[15], s[14:0]}; sample_valid <= 1 for that one clk; F <= {sample_o_new, sample_o_new}.
  - The window is exactly WIN inputs. Overflow is impossible by width.
- Latency: a new sample's MSB appears on sdata at slot 1, i.e. 2*BCLK_DIV clks after sample_valid.
- The first frame after reset transmits F=0 (silence). The first valid sample is at clk WIN-1 after reset release.
- audio_en toggling mid-window: per-clk substitution, no window restart.
- Reset asserted mid-frame: immediate return to reset values; the partial window is discarded.
- No backpressure; the sample stream is free-running.

Decomposition:
- Shared package apu_pkg:
  - I2S_SLOTS=32 and AUDIO_OUT_W=16 constants.
  - Function for offset-binary to two's-complement conversion.
- One natural sub-module: apu_i2s_ser. It takes p, F, and the prior LSB, and produces the registered bclk/lrclk/sdata. The decimator stays in the top.

Test Plan:
- BCLK_DIV=1, audio=16'hC000, en=1 for 200 clks -> sample_valid at clk 63, 127, 191; sample_o=16'h4000; sdata carries 0100_0000_0000_0000 starting at slot 1 and again at slot 17 of the frame after each strobe.
- BCLK_DIV=1, en=0 with any audio -> sample_o=16'h0000, sdata all zeros after the first frame.
- BCLK_DIV=1, audio alternating 16'h0000/16'hFFFF each clk -> sum 32*FFFF, floor average 16'h7FFF, so sample_o=16'hFFFF; right LSB of 1 appears at slot 0 of the next frame.
- BCLK_DIV=4 -> bclk period 8 clks, lrclk period 256 clks. lrclk and sdata change only on bclk falling edges; lrclk falls when p wraps to 0 and rises at p=128.
- AUDIO_DEPTH=8, audio=8'hFF, en=1 -> x=16'hFF00, sample_o=16'h7F00.
- Async rst pulse at p=37, asserted between clk edges -> all outputs 0 immediately without a clk edge. After release, the first sample_valid occurs WIN-1 clks later with only post-reset inputs averaged.
